// File: rtl/maze_pkg.sv
// Shared constants and FSM state encoding for the maze loader.
// The ROM holds NUM_MAZES images of MAZE_WORDS words each, stored back-to-back.
package maze_pkg;

    localparam int MAZE_WORDS      = 600;
    localparam int MAZE_COLS_WORDS = 5;
    localparam int CELL_SHIFT      = 2;
    localparam int NUM_MAZES       = 4;
    localparam int MAZE_ROM_AW     = 12;
    localparam int MAZE_SEL_W      = 2;
    localparam int AVM_AW          = 10;
    localparam int AVM_DW          = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        WRITE,
        DONE
    } mw_state_t;

endpackage

// File: rtl/maze_writer_avl_master_if.sv
// Avalon-MM write-only link between the maze loader and the VGA/game
// interface register file.
interface maze_writer_avl_master_if;
    import maze_pkg::*;

    logic [AVM_AW-1:0] AVM_ADDR;
    logic              AVM_WRITE;
    logic              AVM_CS;
    logic [3:0]        AVM_BYTE_EN;
    logic [AVM_DW-1:0] AVM_WRITEDATA;
    logic              AVM_WAITREQUEST;

    modport master (
        output AVM_ADDR,
        output AVM_WRITE,
        output AVM_CS,
        output AVM_BYTE_EN,
        output AVM_WRITEDATA,
        input  AVM_WAITREQUEST
    );

    modport slave (
        input  AVM_ADDR,
        input  AVM_WRITE,
        input  AVM_CS,
        input  AVM_BYTE_EN,
        input  AVM_WRITEDATA,
        output AVM_WAITREQUEST
    );

endinterface

// File: rtl/maze_writer_avl_master.sv
// Copies one maze image from the maze ROM into slave words 0..MAZE_WORDS-1,
// one write per word, then holds maze_ready until the next load is started.
module maze_writer_avl_master #(
    parameter int MAZE_WORDS = maze_pkg::MAZE_WORDS,
    parameter int NUM_MAZES  = maze_pkg::NUM_MAZES,
    parameter int ROM_AW     = maze_pkg::MAZE_ROM_AW,
    parameter int SEL_W      = maze_pkg::MAZE_SEL_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     start,
    input  logic [SEL_W-1:0]         maze_sel,
    output logic [ROM_AW-1:0]        rom_addr,
    input  logic [31:0]              rom_rddata,
    maze_writer_avl_master_if.master avm,
    output logic                     busy,
    output logic                     maze_ready
);
    import maze_pkg::*;

    localparam int unsigned MAX_SEL  = NUM_MAZES - 1;
    localparam logic [9:0]  LAST_IDX = 10'(MAZE_WORDS - 1);

    mw_state_t         state_reg;
    logic [9:0]        idx_reg;
    logic [ROM_AW-1:0] rom_addr_reg;
    logic [9:0]        avm_addr_reg;
    logic [31:0]       avm_wdata_reg;
    logic              avm_write_reg;
    logic              busy_reg;
    logic              ready_reg;

    logic [SEL_W-1:0]  sel_clamped;
    logic [ROM_AW-1:0] base_addr;
    logic              accept_start;

    // Out-of-range selections map onto the last stored maze.
    always_comb begin
        sel_clamped = maze_sel;
        if (32'(maze_sel) > MAX_SEL) begin
            sel_clamped = SEL_W'(MAX_SEL);
        end
        base_addr = ROM_AW'(32'(sel_clamped) * MAZE_WORDS);
    end

    assign accept_start = start && ((state_reg == IDLE) || (state_reg == DONE));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            rom_addr_reg  <= '0;
            avm_addr_reg  <= '0;
            avm_wdata_reg <= '0;
            avm_write_reg <= 1'b0;
            busy_reg      <= 1'b0;
            ready_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (accept_start) begin
                        idx_reg      <= '0;
                        rom_addr_reg <= base_addr;
                        busy_reg     <= 1'b1;
                        ready_reg    <= 1'b0;
                        state_reg    <= FETCH;
                    end
                end
                // ROM registers rom_addr at this edge; data is usable in WAIT.
                FETCH: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    avm_wdata_reg <= rom_rddata;
                    avm_addr_reg  <= idx_reg;
                    avm_write_reg <= 1'b1;
                    state_reg     <= WRITE;
                end
                WRITE: begin
                    if (!avm.AVM_WAITREQUEST) begin
                        avm_write_reg <= 1'b0;
                        if (idx_reg == LAST_IDX) begin
                            busy_reg  <= 1'b0;
                            ready_reg <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            idx_reg      <= idx_reg + 10'd1;
                            rom_addr_reg <= rom_addr_reg + ROM_AW'(1);
                            state_reg    <= FETCH;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    avm_write_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr          = rom_addr_reg;
    assign busy              = busy_reg;
    assign maze_ready        = ready_reg;
    assign avm.AVM_ADDR      = avm_addr_reg;
    assign avm.AVM_WRITE     = avm_write_reg;
    assign avm.AVM_CS        = avm_write_reg;
    assign avm.AVM_BYTE_EN   = 4'hF;
    assign avm.AVM_WRITEDATA = avm_wdata_reg;

endmodule

// File: tb/tb_maze_writer_avl_master.sv
// Directed bench for the maze loader: ROM model, Avalon slave stall driver,
// and per-write address/data scoreboard checked with immediate assertions.
module tb_maze_writer_avl_master;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  maze_sel = 2'd0;
    logic [11:0] rom_addr;
    logic [31:0] rom_rddata;
    logic        busy;
    logic        maze_ready;

    logic [11:0] rom_q;
    logic [31:0] rom_pat = 32'h0;

    int n_checks = 0;
    int n_fails  = 0;

    maze_writer_avl_master_if avm_if ();

    maze_writer_avl_master dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .start      (start),
        .maze_sel   (maze_sel),
        .rom_addr   (rom_addr),
        .rom_rddata (rom_rddata),
        .avm        (avm_if),
        .busy       (busy),
        .maze_ready (maze_ready)
    );

    always #10 CLK = ~CLK;

    // maze_rom_model: registered address, unregistered q; word k = pattern | k
    always @(posedge CLK) rom_q <= rom_addr;
    assign rom_rddata = rom_pat | {20'd0, rom_q};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one complete load and scores every write.
    task automatic run_load(input logic [1:0] sel, input logic [31:0] pat, input bit stalls,
                            input int extra_start, input int exp_cycles);
        int cycles, nwr, rdy_cycle, stall_left;
        int base;
        bit in_write, prev_stalled;
        logic [9:0]  prev_addr;
        logic [31:0] prev_data;
        base = int'(sel) * 600;
        rom_pat = pat;
        cycles = 0; nwr = 0; rdy_cycle = -1; stall_left = 0;
        in_write = 0; prev_stalled = 0; prev_addr = '0; prev_data = '0;
        @(negedge CLK);
        maze_sel = sel;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        maze_sel = ~sel;
        while (cycles < exp_cycles + 50) begin
            @(negedge CLK);
            start = 1'b0;
            if (cycles == 0) begin
                check("ready_low_after_start", {31'd0, maze_ready}, 32'd0);
                check("busy_after_start", {31'd0, busy}, 32'd1);
            end
            if (maze_ready) begin
                rdy_cycle = cycles;
                check("busy_falls_with_ready", {31'd0, busy}, 32'd0);
                break;
            end
            if (rom_addr < 12'(base) || rom_addr > 12'(base + 599)) begin
                check("rom_addr_range", {20'd0, rom_addr}, 32'(base));
            end
            check("cs_eq_write", {31'd0, avm_if.AVM_CS}, {31'd0, avm_if.AVM_WRITE});
            if (prev_stalled) begin
                check("stall_write_held", {31'd0, avm_if.AVM_WRITE}, 32'd1);
                check("stall_addr_held", {22'd0, avm_if.AVM_ADDR}, {22'd0, prev_addr});
                check("stall_data_held", avm_if.AVM_WRITEDATA, prev_data);
            end
            avm_if.AVM_WAITREQUEST = 1'b0;
            prev_stalled = 0;
            if (avm_if.AVM_WRITE) begin
                if (!in_write) begin
                    in_write = 1;
                    stall_left = (stalls && (avm_if.AVM_ADDR % 7 == 0)) ? 4 : 0;
                end
                if (stall_left > 0) begin
                    avm_if.AVM_WAITREQUEST = 1'b1;
                    stall_left--;
                    prev_stalled = 1;
                    prev_addr = avm_if.AVM_ADDR;
                    prev_data = avm_if.AVM_WRITEDATA;
                end else begin
                    in_write = 0;
                    check("wr_addr", {22'd0, avm_if.AVM_ADDR}, 32'(nwr));
                    check("wr_data", avm_if.AVM_WRITEDATA, pat | 32'(base + nwr));
                    check("wr_byte_en", {28'd0, avm_if.AVM_BYTE_EN}, 32'hF);
                    nwr++;
                end
            end
            if (cycles == extra_start) begin
                start = 1'b1;
                maze_sel = 2'd3;
            end
            @(posedge CLK);
            cycles++;
        end
        avm_if.AVM_WAITREQUEST = 1'b0;
        check("write_count", 32'(nwr), 32'd600);
        check("ready_cycle", 32'(rdy_cycle), 32'(exp_cycles));
        $display("load sel=%0d pat=%08h stalls=%0d: %0d writes, ready after %0d cycles",
                 sel, pat, stalls, nwr, rdy_cycle);
    endtask

    initial begin
        int guard;
        bit found;
        avm_if.AVM_WAITREQUEST = 1'b0;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_write", {31'd0, avm_if.AVM_WRITE}, 32'd0);
        check("rst_cs", {31'd0, avm_if.AVM_CS}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, maze_ready}, 32'd0);
        check("rst_rom_addr", {20'd0, rom_addr}, 32'd0);
        check("rst_avm_addr", {22'd0, avm_if.AVM_ADDR}, 32'd0);
        check("rst_wdata", avm_if.AVM_WRITEDATA, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check("post_rst_write", {31'd0, avm_if.AVM_WRITE}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        $display("reset state checked");

        run_load(2'd0, 32'hA500_0000, 1'b0, -1, 1800);
        run_load(2'd1, 32'h0, 1'b0, -1, 1800);
        run_load(2'd2, 32'h0, 1'b0, -1, 1800);
        run_load(2'd0, 32'h5A00_0000, 1'b0, 500, 1800);
        run_load(2'd3, 32'h0, 1'b0, -1, 1800);
        run_load(2'd0, 32'hC300_0000, 1'b1, -1, 2144);

        // Abort mid-load while the write of word 300 is on the bus.
        rom_pat = 32'hA500_0000;
        @(negedge CLK);
        maze_sel = 2'd0;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        found = 0;
        for (guard = 0; guard < 2000; guard++) begin
            @(negedge CLK);
            if (avm_if.AVM_WRITE && avm_if.AVM_ADDR == 10'd300) begin
                found = 1;
                break;
            end
        end
        check("reach_word_300", {31'd0, found}, 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("abort_write", {31'd0, avm_if.AVM_WRITE}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, maze_ready}, 32'd0);
        check("abort_avm_addr", {22'd0, avm_if.AVM_ADDR}, 32'd0);
        repeat (5) begin
            @(negedge CLK);
            check("idle_no_write", {31'd0, avm_if.AVM_WRITE}, 32'd0);
            check("idle_not_ready", {31'd0, maze_ready}, 32'd0);
        end
        $display("reset mid-load checked");
        run_load(2'd0, 32'hA500_0000, 1'b0, -1, 1800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/maze_writer_avl_master.md
Name: maze_writer_avl_master

Overview:
Avalon-MM write master that fills the VGA/game interface's 600-word maze register file from an on-chip maze ROM.
- On a start request it copies one selected maze image, word by word, to slave addresses 0..599.
- It then raises maze_ready so the game state machine can leave the title and loading phase.
- It sits between the maze ROM and the Avalon-MM slave port of the VGA text/game interface, and is the initiator for that slave.

Parameters:
MAZE_WORDS, 600, number of 32-bit words per maze (one bit per 4x4 pixel cell, 160x120 cells)
NUM_MAZES, 4, number of maze images stored back-to-back in the ROM
ROM_AW, 12, ROM word-address width; must satisfy NUM_MAZES*MAZE_WORDS <= 2**ROM_AW
SEL_W, 2, width of maze_sel, equal to clog2(NUM_MAZES)

Ports:
CLK  in  1  system clock, 50 MHz
RESET  in  1  synchronous, active-high reset
start  in  1  one-cycle load request; sampled only in IDLE or DONE
maze_sel  in  SEL_W  maze index; latched on an accepted start
rom_addr  out  ROM_AW  registered ROM word address
rom_rddata  in  32  ROM data, valid the cycle after rom_addr is sampled (altsyncram: registered address, unregistered q)
AVM_ADDR  out  10  slave word address
AVM_WRITE  out  1  write strobe
AVM_CS  out  1  chip select; always equal to AVM_WRITE
AVM_BYTE_EN  out  4  fixed at 4'hF
AVM_WRITEDATA  out  32  write data
AVM_WAITREQUEST  in  1  slave stall; tie to 0 for the current zero-wait slave
busy  out  1  high from an accepted start until the last write completes
maze_ready  out  1  level: a full maze is resident in the slave

Behaviour:
Clock and reset:
- Reset RESET is synchronous, active-high; clock CLK.
- While RESET is high, and on the cycle after it: state IDLE, idx=0, rom_addr=0, AVM_ADDR=0, AVM_WRITE=0, AVM_CS=0, AVM_WRITEDATA=0, busy=0, maze_ready=0.
- RESET mid-load aborts immediately. No further writes are issued, and maze_ready stays 0 until a new load completes.

State machine (registered; one word index idx, 10 bits):
- IDLE: start=1 -> latch sel=maze_sel; idx=0; rom_addr=sel*MAZE_WORDS; busy=1; maze_ready=0; go to FETCH.
- FETCH: rom_addr is stable this cycle and the ROM samples it at the next edge -> go to WAIT.
- WAIT: rom_rddata is valid. Register AVM_WRITEDATA=rom_rddata and AVM_ADDR=idx; set AVM_WRITE=AVM_CS=1 -> go to WRITE.
- WRITE: hold AVM_ADDR, AVM_WRITEDATA and AVM_WRITE stable while AVM_WAITREQUEST=1. At the first edge with AVM_WAITREQUEST=0 the transfer completes and AVM_WRITE drops to 0 next cycle. Then:
  - if idx==MAZE_WORDS-1: go to DONE, busy=0, maze_ready=1;
  - else: idx=idx+1, rom_addr=rom_addr+1, go to FETCH.
- DONE: maze_ready=1 held. start=1 -> same action as start in IDLE; maze_ready drops to 0 on the next cycle.

Timing and arithmetic rules:
- With zero wait states each word takes 3 cycles. maze_ready rises exactly 3*MAZE_WORDS = 1800 cycles after the edge that accepts start.
- Exactly one write strobe-completion per word. No write is ever issued with AVM_ADDR >= MAZE_WORDS.
- Base address is sel*MAZE_WORDS, computed in ROM_AW bits and never truncated (max 1800+599 = 2399).
- maze_sel >= NUM_MAZES is clamped to NUM_MAZES-1.

Boundary conditions:
- start while busy (FETCH/WAIT/WRITE) is ignored. maze_sel changes while busy have no effect.
- start on the same cycle that the last write completes is ignored. A new load requires start in DONE.
- AVM_WAITREQUEST held high indefinitely stalls in WRITE with all outputs stable. There is no timeout.

Decomposition:
- Package maze_pkg holds:
  - constants MAZE_WORDS=600, MAZE_COLS_WORDS=5, CELL_SHIFT=2, NUM_MAZES;
  - typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} mw_state_t.
- No sub-module needed. A behavioural maze ROM model (maze_rom_model) lives in the testbench only.

Test Plan:
- Basic load: ROM word k = 32'hA5000000|k, maze_sel=0, start pulse, waitrequest=0 -> 600 writes, addr 0..599 with data A5000000..A5000257, maze_ready rises 1800 cycles after start, busy falls on the same edge.
- Maze select: maze_sel=2, ROM word k = k -> first write data 1200 at addr 0, last write data 1799 at addr 599; rom_addr never outside 1200..1799.
- Wait states: waitrequest high for 4 cycles on every 7th word -> AVM_ADDR/WRITEDATA/WRITE stable throughout each stall, no duplicate or missing address, maze_ready at 1800 + 4*86 = 2144 cycles.
- Start while busy: second start at cycle 500 with maze_sel=3 -> ignored; data still from maze 0, single maze_ready rise.
- Reset mid-load: RESET at word 300 for 1 cycle -> AVM_WRITE=0, maze_ready=0, busy=0 next cycle. A new start then reloads all 600 words from addr 0.
- Reload from DONE: start in DONE with maze_sel=1 -> maze_ready low the next cycle, 600 writes of maze 1, maze_ready high again after 1800 cycles.
